// File: rtl/rl_dma_xfer.sv
// Word-block transfer engine for the RL disk controller, upstream of the rlmem port.
// Converts one command (byte address, word count, direction) into single-word rlmem requests,
// fed from a disk->memory valid/ready stream or feeding a memory->disk valid/ready stream.
// Optional build macro RLDMA_TIMEOUT_EN: abort with err if rlmemack does not arrive within
// TIMEOUT cycles of the request.
module rl_dma_xfer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_wc,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        din_valid,
  input  logic [15:0] din_data,
  output logic        din_ready,
  output logic        dout_valid,
  output logic [15:0] dout_data,
  input  logic        dout_ready,
  output logic        rlmemreq,
  output logic        rlmemwr,
  output logic [31:0] rlmemaddr,
  output logic [15:0] rlmemwdata,
  input  logic        rlmemack,
  input  logic [15:0] rlmemrdata
);

  typedef enum logic [2:0] {StIdle, StFetch, StReq, StWait, StPush, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
`ifdef RLDMA_TIMEOUT_EN
  // Counts cycles since the request; 1 in the first WAIT cycle.
  logic [31:0] tmo_q, tmo_d;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef RLDMA_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
`ifdef RLDMA_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
`ifdef RLDMA_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          addr_d = cmd_addr;
          rem_d  = cmd_wc;
          wr_d   = cmd_wr;
          err_d  = 1'b0;
          if (cmd_addr[0]) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (cmd_wc == 16'd0) begin
            state_d = StDone;
          end else begin
            state_d = cmd_wr ? StFetch : StReq;
          end
        end
      end
      StFetch: begin
        if (din_valid) begin
          wdata_d = din_data;
          state_d = StReq;
        end
      end
      StReq: begin
        state_d = StWait;
`ifdef RLDMA_TIMEOUT_EN
        tmo_d   = 32'd1;
`endif
      end
      StWait: begin
        if (rlmemack) begin
          addr_d = addr_q + 32'd2;
          rem_d  = rem_q - 16'd1;
          if (wr_q) begin
            state_d = (rem_q == 16'd1) ? StDone : StFetch;
          end else begin
            rdata_d = rlmemrdata;
            state_d = StPush;
          end
        end
`ifdef RLDMA_TIMEOUT_EN
        // Ack in the final cycle still wins over the timeout.
        else if (tmo_q >= TIMEOUT - 1) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      StPush: begin
        if (dout_ready) begin
          state_d = (rem_q == 16'd0) ? StDone : StReq;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state or taken straight from registers.
  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    din_ready  = (state_q == StFetch);
    dout_valid = (state_q == StPush);
    rlmemreq   = (state_q == StReq);
    err        = err_q;
    rlmemwr    = wr_q;
    rlmemaddr  = addr_q;
    rlmemwdata = wdata_q;
    dout_data  = rdata_q;
  end

endmodule

// File: tb/tb_rl_dma_xfer.sv
// Self-checking bench for rl_dma_xfer: transaction-level model of expected requests,
// output words and completion status, checked every cycle, plus directed literal checks.
module tb_rl_dma_xfer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_wc = '0;
  logic        busy, done, err;
  logic        din_valid = 1'b0;
  logic [15:0] din_data = '0;
  logic        din_ready;
  logic        dout_valid;
  logic [15:0] dout_data;
  logic        dout_ready = 1'b0;
  logic        rlmemreq, rlmemwr;
  logic [31:0] rlmemaddr;
  logic [15:0] rlmemwdata;
  logic        rlmemack = 1'b0;
  logic [15:0] rlmemrdata = '0;

  always #5 clk = ~clk;

  rl_dma_xfer #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_start  (cmd_start),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_wc     (cmd_wc),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .din_valid  (din_valid),
    .din_data   (din_data),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_ready (dout_ready),
    .rlmemreq   (rlmemreq),
    .rlmemwr    (rlmemwr),
    .rlmemaddr  (rlmemaddr),
    .rlmemwdata (rlmemwdata),
    .rlmemack   (rlmemack),
    .rlmemrdata (rlmemrdata)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [15:0] wdata;
  } req_t;
  req_t        exp_req[$];
  logic [15:0] exp_dout[$];
  logic [15:0] din_q[$];
  logic [15:0] rd_q[$];
  logic [31:0] req_log[$];
  logic        exp_err = 1'b0;
  bit          exp_tmo = 1'b0;
  bit          outstanding = 1'b0;
  bit          push_pending = 1'b0;
  logic [31:0] hold_addr;
  logic        hold_wr;
  logic [15:0] hold_wdata;
  int          done_cnt = 0, req_cnt = 0, cyc = 0, req_cyc = 0, done_cyc = 0, dv_cycles = 0;

  // Environment controls
  bit resp_en = 1'b1;
  bit stray_ack = 1'b0;
  int ack_delay = 2;
  int dout_hold = 0;
  int hold_cnt = 0;
  bit din_hs;

  // Compare process: checks DUT against the transaction model every cycle.
  always @(negedge clk) begin
    req_t r;
    cyc++;
    if (rst) begin
      outstanding  = 1'b0;
      push_pending = 1'b0;
      exp_req.delete();
      exp_dout.delete();
    end else begin
      if (outstanding) begin
        chk("hold_addr", rlmemaddr, hold_addr);
        chk("hold_wr", {31'b0, rlmemwr}, {31'b0, hold_wr});
        if (hold_wr) chk("hold_wdata", {16'b0, rlmemwdata}, {16'b0, hold_wdata});
      end
      if (rlmemreq) begin
        req_cnt++;
        req_cyc = cyc;
        req_log.push_back(rlmemaddr);
        chk("req_allowed", {31'b0, !outstanding && !push_pending && exp_req.size() != 0}, 1);
        if (exp_req.size() != 0) begin
          r = exp_req.pop_front();
          chk("req_addr", rlmemaddr, r.addr);
          chk("req_wr", {31'b0, rlmemwr}, {31'b0, r.wr});
          if (r.wr) chk("req_wdata", {16'b0, rlmemwdata}, {16'b0, r.wdata});
          hold_addr   = rlmemaddr;
          hold_wr     = rlmemwr;
          hold_wdata  = rlmemwdata;
          outstanding = 1'b1;
        end
      end else if (outstanding && rlmemack) begin
        outstanding = 1'b0;
        if (!hold_wr) push_pending = 1'b1;
      end
      if (dout_valid) begin
        dv_cycles++;
        chk("dout_expected", {31'b0, push_pending && exp_dout.size() != 0}, 1);
        if (exp_dout.size() != 0) begin
          chk("dout_data", {16'b0, dout_data}, {16'b0, exp_dout[0]});
          if (dout_ready) begin
            void'(exp_dout.pop_front());
            push_pending = 1'b0;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_err", {31'b0, err}, {31'b0, exp_err});
        chk("done_busy", {31'b0, busy}, 1);
        chk("done_complete", {31'b0, exp_tmo || (exp_req.size() == 0 && !outstanding)}, 1);
        chk("done_no_push", {31'b0, push_pending}, 0);
        if (exp_tmo) begin
          exp_req.delete();
          outstanding = 1'b0;
        end
      end
    end
  end

  // Disk->memory source: presents the head of din_q, pops on handshake.
  always begin
    @(negedge clk);
    din_hs = din_valid && din_ready;
    @(posedge clk);
    #1;
    if (din_hs && din_q.size() > 0) void'(din_q.pop_front());
    din_valid = (din_q.size() > 0);
    din_data  = din_valid ? din_q[0] : 16'h0;
  end

  // Memory->disk sink: holds dout_ready low for dout_hold cycles of each word.
  always begin
    @(posedge clk);
    #1;
    if (dout_valid) begin
      dout_ready = (hold_cnt >= dout_hold);
      hold_cnt++;
    end else begin
      dout_ready = 1'b0;
      hold_cnt   = 0;
    end
  end

  // rlmem responder: ack ack_delay cycles after each request.
  always begin
    @(posedge clk);
    #1;
    if (stray_ack) begin
      stray_ack  = 1'b0;
      rlmemack   = 1'b1;
      rlmemrdata = 16'hDEAD;
      @(posedge clk);
      #1;
      rlmemack   = 1'b0;
      rlmemrdata = 16'h0;
    end else if (rlmemreq && resp_en) begin
      repeat (ack_delay) @(posedge clk);
      #1;
      rlmemack   = 1'b1;
      rlmemrdata = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0;
      @(posedge clk);
      #1;
      rlmemack   = 1'b0;
      rlmemrdata = 16'h0;
    end
  end

  // Loads the model for one command, then pulses cmd_start for one cycle.
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] wc);
    req_t r;
    exp_err = addr[0];
    exp_tmo = 1'b0;
    if (!addr[0]) begin
      for (int i = 0; i < int'(wc); i++) begin
        r.addr  = addr + 32'(2 * i);
        r.wr    = wr;
        r.wdata = wr ? din_q[i] : 16'h0;
        exp_req.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wc    = wc;
    cmd_start = 1'b1;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int d0 = done_cnt;
    for (int k = 0; k < max_cycles && done_cnt == d0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_din_ready", {31'b0, din_ready}, 0);
    chk("rst_dout_valid", {31'b0, dout_valid}, 0);
    chk("rst_rlmemreq", {31'b0, rlmemreq}, 0);
    chk("rst_rlmemwr", {31'b0, rlmemwr}, 0);
    chk("rst_rlmemaddr", rlmemaddr, 0);
    chk("rst_rlmemwdata", {16'b0, rlmemwdata}, 0);
    chk("rst_dout_data", {16'b0, dout_data}, 0);
  endtask

  initial begin
    int d0, r0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;

    // 1: write three words, ack 2 cycles after each request
    ack_delay = 2;
    din_q = '{16'h00A1, 16'h00A2, 16'h00A3};
    d0 = done_cnt;
    r0 = req_cnt;
    do_cmd(1'b1, 32'h100, 16'd3);
    chk("t1_busy", {31'b0, busy}, 1);
    wait_done(200);
    repeat (3) @(negedge clk);
    #1;
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_reqs", req_cnt - r0, 3);
    chk("t1_addr0", req_log[r0], 32'h100);
    chk("t1_addr2", req_log[r0 + 2], 32'h104);
    chk("t1_err", {31'b0, err}, 0);

    // 2: read two words, sink stalls 5 cycles per word
    dout_hold = 5;
    rd_q      = '{16'h1111, 16'h2222};
    exp_dout  = '{16'h1111, 16'h2222};
    dv_cycles = 0;
    r0 = req_cnt;
    do_cmd(1'b0, 32'h200, 16'd2);
    wait_done(200);
    chk("t2_dv_cycles", dv_cycles, 12);
    chk("t2_reqs", req_cnt - r0, 2);
    chk("t2_addr1", req_log[r0 + 1], 32'h202);
    dout_hold = 0;

    // 3: zero word count, start during done ignored, then odd address
    r0 = req_cnt;
    do_cmd(1'b1, 32'h300, 16'd0);
    chk("t3_done_wc0", {31'b0, done}, 1);
    chk("t3_err_wc0", {31'b0, err}, 0);
    cmd_addr  = 32'h301;
    cmd_wc    = 16'd4;
    cmd_start = 1'b1;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    chk("t3_ignored_busy", {31'b0, busy}, 0);
    chk("t3_ignored_err", {31'b0, err}, 0);
    do_cmd(1'b0, 32'h301, 16'd5);
    chk("t3_done_odd", {31'b0, done}, 1);
    chk("t3_err_odd", {31'b0, err}, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("t3_no_reqs", req_cnt - r0, 0);

    // 4: read across the 32-bit address wrap
    rd_q     = '{16'hBEEF, 16'hCAFE};
    exp_dout = '{16'hBEEF, 16'hCAFE};
    r0 = req_cnt;
    do_cmd(1'b0, 32'hFFFF_FFFE, 16'd2);
    wait_done(200);
    chk("t4_addr0", req_log[r0], 32'hFFFF_FFFE);
    chk("t4_addr1", req_log[r0 + 1], 32'h0);
    chk("t4_err", {31'b0, err}, 0);

    // 5: reset while waiting for ack, stray ack after reset, then a fresh write
    resp_en = 1'b0;
    r0 = req_cnt;
    do_cmd(1'b0, 32'h500, 16'd1);
    for (int k = 0; k < 20 && req_cnt == r0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("t5_req_seen", req_cnt - r0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals();
    d0 = done_cnt;
    r0 = req_cnt;
    repeat (4) @(negedge clk);
    #1;
    chk("t5_stray_no_req", req_cnt - r0, 0);
    chk("t5_stray_no_done", done_cnt - d0, 0);
    chk("t5_stray_idle", {31'b0, busy}, 0);
    resp_en = 1'b1;
    din_q   = '{16'h5A5A};
    do_cmd(1'b1, 32'h600, 16'd1);
    wait_done(200);
    chk("t5_new_addr", req_log[req_log.size() - 1], 32'h600);
    chk("t5_new_err", {31'b0, err}, 0);

`ifdef RLDMA_TIMEOUT_EN
    // 6: no ack ever; abort 16 cycles after the request
    resp_en = 1'b0;
    din_q   = '{16'h7777, 16'h8888};
    r0 = req_cnt;
    do_cmd(1'b1, 32'h700, 16'd2);
    exp_err = 1'b1;
    exp_tmo = 1'b1;
    wait_done(200);
    chk("t6_latency", done_cyc - req_cyc, 16);
    repeat (5) @(negedge clk);
    #1;
    chk("t6_one_req", req_cnt - r0, 1);
    chk("t6_err", {31'b0, err}, 1);
    din_q.delete();
    resp_en = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
